rec_play_ctrl: RTL and testbench
================================

# rec_play_ctrl

Parametrised successor to the recorder/player top-level controller. It sequences WM8731 I2C initialisation, then arbitrates record, play, pause and stop across 2^SLOT_W independent SRAM recording slots. It tracks the recorded end address of each slot and drives the recorder, DSP and player enables. It sits between the key front end and the AudRecorder / AudDSP / AudPlayer / I2CInitializer instances, and owns the SRAM write-enable and address-base selection.

## Interface
- ADDR_W, 20: SRAM word-address width.
- SLOT_W, 2: log2 of the slot count; the slot base is `slot << (ADDR_W-SLOT_W)`.
- INIT_CYC, 2048: number of cycles `o_i2c_start` is held high after reset (≥1).

Ports:
- i_clk  in  1  single clock (audio BCLK domain)
- i_rst_n  in  1  asynchronous active-low reset
- i_key_rec / i_key_play / i_key_stop  in  1 each  one-cycle debounced key pulses
- i_slot  in  SLOT_W  slot select; sampled only on a start from IDLE
- i_i2c_fin  in  1  I2C initialiser done (level)
- i_rec_addr  in  ADDR_W  recorder's current write address
- i_rec_fin  in  1  recorder hit the slot end (pulse)
- i_play_fin  in  1  DSP reached `o_stop_addr` (pulse)
- o_i2c_start  out  1  I2C start request
- o_rec_start / o_rec_pause / o_rec_stop  out  1 each  recorder controls
- o_dsp_start / o_dsp_pause / o_dsp_stop  out  1 each  DSP controls
- o_play_en  out  1  player enable
- o_sram_we_n  out  1  SRAM write enable (active low)
- o_base_addr  out  ADDR_W  base address of the active slot
- o_stop_addr  out  ADDR_W  recorded end address of the active slot
- o_slot_valid  out  2^SLOT_W  per-slot "holds a recording" flags
- o_state  out  3  current state encoding

## Operation
- States (encoding): IDLE=0, INIT=1, RECD=2, RECD_PAUSE=3, PLAY=4, PLAY_PAUSE=5. Reset enters INIT.
- INIT
  - `o_i2c_start`=1 while the init counter is < INIT_CYC; the counter saturates and the output then drops.
  - Leaves INIT for IDLE on `i_i2c_fin`=1.
  - All keys are ignored in INIT.
- IDLE
  - `i_key_rec` latches `i_slot` into the active slot and goes to RECD.
  - Otherwise, `i_key_play` goes to PLAY only if `o_slot_valid[i_slot]`=1. It latches the slot first. A play on an empty slot is ignored and the state stays IDLE.
- RECD
  - `i_key_stop` or `i_rec_fin` goes to IDLE. The length table entry for the active slot is written with `i_rec_addr` and its valid bit is set.
  - Otherwise `i_key_rec` goes to RECD_PAUSE.
- RECD_PAUSE
  - `i_key_stop` goes to IDLE with the same store as in RECD.
  - `i_key_rec` goes to RECD.
- PLAY
  - `i_key_stop` goes to IDLE.
  - `i_play_fin` goes to IDLE; behaviour under the macro is in Configuration.
  - Otherwise `i_key_play` goes to PLAY_PAUSE.
- PLAY_PAUSE
  - `i_key_stop` goes to IDLE.
  - `i_key_play` goes to PLAY.
- Priority within a state: stop/fin > rec > play. Simultaneous rec+play in IDLE selects record.
- Level outputs, each high exactly while in the listed state(s):
  - `o_rec_start`: RECD.
  - `o_rec_pause`: RECD_PAUSE.
  - `o_dsp_start` and `o_play_en`: PLAY.
  - `o_dsp_pause`: PLAY_PAUSE.
  - `o_sram_we_n`=0 only in RECD.
- Pulse outputs: `o_rec_stop` / `o_dsp_stop` pulse for exactly 1 cycle on the edge that leaves record / play states for IDLE.
- Address outputs:
  - `o_base_addr` = active slot << (ADDR_W-SLOT_W).
  - `o_stop_addr` = length table entry of the active slot.
- Re-recording a valid slot overwrites its length entry on stop.

## Timing
- All outputs are registered. They update on the same i_clk edge as the state register, so a key sampled at edge N is reflected at edge N.
- Reset values:
  - `o_state`=1; `o_i2c_start`=0, then 1 from the first clock after reset release.
  - All other controls 0; `o_sram_we_n`=1.
  - `o_base_addr`=0; `o_stop_addr`=0.
  - `o_slot_valid`=0; the length table is cleared.
- Reset asserted mid-record aborts without storing. No stop pulse is issued.
- The length table write and the valid bit set occur on the exit edge. They are visible on `o_stop_addr` / `o_slot_valid` the next cycle.

## Configuration
- `REC_PLAY_LOOP_EN`
  - Defined: `i_play_fin` in PLAY does not leave PLAY. It produces a 1-cycle `o_dsp_stop` pulse with `o_dsp_start` low for that cycle. `o_dsp_start` re-asserts the following cycle, and `o_play_en` stays high throughout.
  - Undefined: `i_play_fin` exits to IDLE as specified above.

## Test plan
- Reset release with INIT_CYC=4 and `i_i2c_fin` raised at cycle 10 -> `o_i2c_start` is high for cycles 1–4, and `o_state` goes 1→0 at cycle 10.
- IDLE, `i_slot`=2, rec pulse, `i_rec_addr`=0x8_0123, then stop pulse -> `o_sram_we_n` is low during RECD; `o_rec_stop` pulses once; `o_slot_valid`=4'b0100; `o_stop_addr`=0x8_0123; `o_base_addr`=0x8_0000.
- Play pulse on empty slot 1 -> state stays 0 and no controls toggle. Play on slot 2 -> `o_dsp_start`=`o_play_en`=1 and `o_stop_addr`=0x8_0123.
- PLAY: play pulse, play pulse, then stop and play keys in the same cycle -> states 4→5→4→0, with one `o_dsp_stop` pulse.
- Macro defined, `i_play_fin` in PLAY -> state stays 4; `o_dsp_stop` pulses 1 cycle with `o_dsp_start`=0 that cycle, and `o_dsp_start`=1 afterwards. Macro undefined -> state goes to 0.
- Reset mid-RECD -> all outputs return to reset values and `o_slot_valid`=0.

Source files
------------

// File: rtl/rec_play_ctrl.sv
// Recorder/player top-level controller: I2C init sequencing, record/play/pause/stop
// arbitration over 2^SLOT_W SRAM slots. Optional macro REC_PLAY_LOOP_EN makes playback loop.
module rec_play_ctrl #(
    parameter int ADDR_W   = 20,
    parameter int SLOT_W   = 2,
    parameter int INIT_CYC = 2048
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_key_rec,
    input  logic                  i_key_play,
    input  logic                  i_key_stop,
    input  logic [SLOT_W-1:0]     i_slot,
    input  logic                  i_i2c_fin,
    input  logic [ADDR_W-1:0]     i_rec_addr,
    input  logic                  i_rec_fin,
    input  logic                  i_play_fin,
    output logic                  o_i2c_start,
    output logic                  o_rec_start,
    output logic                  o_rec_pause,
    output logic                  o_rec_stop,
    output logic                  o_dsp_start,
    output logic                  o_dsp_pause,
    output logic                  o_dsp_stop,
    output logic                  o_play_en,
    output logic                  o_sram_we_n,
    output logic [ADDR_W-1:0]     o_base_addr,
    output logic [ADDR_W-1:0]     o_stop_addr,
    output logic [(1<<SLOT_W)-1:0] o_slot_valid,
    output logic [2:0]            o_state
);
    localparam int NSLOT = 1 << SLOT_W;
    localparam int CNT_W = $clog2(INIT_CYC + 1);
    localparam int SHIFT = ADDR_W - SLOT_W;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_INIT       = 3'd1,
        S_RECD       = 3'd2,
        S_RECD_PAUSE = 3'd3,
        S_PLAY       = 3'd4,
        S_PLAY_PAUSE = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                w_latch_slot;
    logic                w_store;
    logic                w_rec_stop;
    logic                w_dsp_stop;
    logic                w_loop_fin;

    logic [CNT_W-1:0]    r_init_cnt;
    logic [SLOT_W-1:0]   r_slot;
    logic [ADDR_W-1:0]   r_len [NSLOT];
    logic [NSLOT-1:0]    r_slot_valid;
    logic [ADDR_W-1:0]   r_stop_addr;
    logic                r_i2c_start;
    logic                r_rec_start;
    logic                r_rec_pause;
    logic                r_rec_stop;
    logic                r_dsp_start;
    logic                r_dsp_pause;
    logic                r_dsp_stop;
    logic                r_play_en;
    logic                r_sram_we_n;

    always_comb begin
        w_next       = r_state;
        w_latch_slot = 1'b0;
        w_store      = 1'b0;
        w_rec_stop   = 1'b0;
        w_dsp_stop   = 1'b0;
        w_loop_fin   = 1'b0;
        case (r_state)
            S_INIT: begin
                if (i_i2c_fin) w_next = S_IDLE;
            end
            S_IDLE: begin
                if (i_key_rec) begin
                    w_next       = S_RECD;
                    w_latch_slot = 1'b1;
                end else if (i_key_play && r_slot_valid[i_slot]) begin
                    w_next       = S_PLAY;
                    w_latch_slot = 1'b1;
                end
            end
            S_RECD: begin
                if (i_key_stop || i_rec_fin) begin
                    w_next     = S_IDLE;
                    w_store    = 1'b1;
                    w_rec_stop = 1'b1;
                end else if (i_key_rec) begin
                    w_next = S_RECD_PAUSE;
                end
            end
            S_RECD_PAUSE: begin
                if (i_key_stop) begin
                    w_next     = S_IDLE;
                    w_store    = 1'b1;
                    w_rec_stop = 1'b1;
                end else if (i_key_rec) begin
                    w_next = S_RECD;
                end
            end
            S_PLAY: begin
                if (i_key_stop) begin
                    w_next     = S_IDLE;
                    w_dsp_stop = 1'b1;
                end else if (i_play_fin) begin
                    w_dsp_stop = 1'b1;
`ifdef REC_PLAY_LOOP_EN
                    // Loop playback: restart the DSP in place without leaving PLAY.
                    w_loop_fin = 1'b1;
`else
                    w_next     = S_IDLE;
`endif
                end else if (i_key_play) begin
                    w_next = S_PLAY_PAUSE;
                end
            end
            S_PLAY_PAUSE: begin
                if (i_key_stop) begin
                    w_next     = S_IDLE;
                    w_dsp_stop = 1'b1;
                end else if (i_key_play) begin
                    w_next = S_PLAY;
                end
            end
            default: w_next = S_INIT;
        endcase
    end

    // Outputs are registered from the next state so a key at edge N shows at edge N.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_INIT;
            r_init_cnt   <= '0;
            r_slot       <= '0;
            r_slot_valid <= '0;
            r_stop_addr  <= '0;
            r_i2c_start  <= 1'b0;
            r_rec_start  <= 1'b0;
            r_rec_pause  <= 1'b0;
            r_rec_stop   <= 1'b0;
            r_dsp_start  <= 1'b0;
            r_dsp_pause  <= 1'b0;
            r_dsp_stop   <= 1'b0;
            r_play_en    <= 1'b0;
            r_sram_we_n  <= 1'b1;
            for (int i = 0; i < NSLOT; i++) r_len[i] <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_INIT && r_init_cnt < CNT_W'(INIT_CYC))
                r_init_cnt <= r_init_cnt + CNT_W'(1);
            r_i2c_start <= (w_next == S_INIT) && (r_init_cnt < CNT_W'(INIT_CYC));
            r_rec_start <= (w_next == S_RECD);
            r_rec_pause <= (w_next == S_RECD_PAUSE);
            r_dsp_start <= (w_next == S_PLAY) && !w_loop_fin;
            r_play_en   <= (w_next == S_PLAY);
            r_dsp_pause <= (w_next == S_PLAY_PAUSE);
            r_sram_we_n <= (w_next != S_RECD);
            r_rec_stop  <= w_rec_stop;
            r_dsp_stop  <= w_dsp_stop;
            if (w_latch_slot) begin
                r_slot      <= i_slot;
                r_stop_addr <= r_len[i_slot];
            end
            if (w_store) begin
                r_len[r_slot]        <= i_rec_addr;
                r_slot_valid[r_slot] <= 1'b1;
                r_stop_addr          <= i_rec_addr;
            end
        end
    end

    assign o_state      = r_state;
    assign o_i2c_start  = r_i2c_start;
    assign o_rec_start  = r_rec_start;
    assign o_rec_pause  = r_rec_pause;
    assign o_rec_stop   = r_rec_stop;
    assign o_dsp_start  = r_dsp_start;
    assign o_dsp_pause  = r_dsp_pause;
    assign o_dsp_stop   = r_dsp_stop;
    assign o_play_en    = r_play_en;
    assign o_sram_we_n  = r_sram_we_n;
    assign o_base_addr  = ADDR_W'(r_slot) << SHIFT;
    assign o_stop_addr  = r_stop_addr;
    assign o_slot_valid = r_slot_valid;

endmodule

// File: tb/tb_rec_play_ctrl.sv
// Self-checking bench for rec_play_ctrl: init sequence, directed vector table,
// mid-record reset, and randomized keys against a behavioural slot/length model.
module tb_rec_play_ctrl;
    localparam int ADDR_W   = 20;
    localparam int SLOT_W   = 2;
    localparam int INIT_CYC = 4;

    // ctl bit order: {i2c, rec_start, rec_pause, rec_stop, dsp_start, dsp_pause, dsp_stop, play_en, we_n}
    localparam logic [8:0] C_IDLE = 9'b000000001;
    localparam logic [8:0] C_RECD = 9'b010000000;
    localparam logic [8:0] C_RPAU = 9'b001000001;
    localparam logic [8:0] C_RSTP = 9'b000100001;
    localparam logic [8:0] C_PLAY = 9'b000010011;
    localparam logic [8:0] C_PPAU = 9'b000001001;
    localparam logic [8:0] C_DSTP = 9'b000000101;
    localparam logic [8:0] C_LOOP = 9'b000000111;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              key_rec = 1'b0, key_play = 1'b0, key_stop = 1'b0;
    logic [1:0]        slot = '0;
    logic              i2c_fin = 1'b0, rec_fin = 1'b0, play_fin = 1'b0;
    logic [ADDR_W-1:0] rec_addr = '0;
    logic              i2c_start, rec_start, rec_pause, rec_stop;
    logic              dsp_start, dsp_pause, dsp_stop, play_en, sram_we_n;
    logic [ADDR_W-1:0] base_addr, stop_addr;
    logic [3:0]        slot_valid;
    logic [2:0]        state;
    logic [8:0]        ctl;

    int total = 0;
    int bad   = 0;

    logic [55:0] exp_q[$];

    always #5 clk = ~clk;

    rec_play_ctrl #(.ADDR_W(ADDR_W), .SLOT_W(SLOT_W), .INIT_CYC(INIT_CYC)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_key_rec(key_rec), .i_key_play(key_play), .i_key_stop(key_stop),
        .i_slot(slot), .i_i2c_fin(i2c_fin), .i_rec_addr(rec_addr),
        .i_rec_fin(rec_fin), .i_play_fin(play_fin),
        .o_i2c_start(i2c_start), .o_rec_start(rec_start), .o_rec_pause(rec_pause),
        .o_rec_stop(rec_stop), .o_dsp_start(dsp_start), .o_dsp_pause(dsp_pause),
        .o_dsp_stop(dsp_stop), .o_play_en(play_en), .o_sram_we_n(sram_we_n),
        .o_base_addr(base_addr), .o_stop_addr(stop_addr),
        .o_slot_valid(slot_valid), .o_state(state)
    );

    assign ctl = {i2c_start, rec_start, rec_pause, rec_stop, dsp_start,
                  dsp_pause, dsp_stop, play_en, sram_we_n};

    typedef struct {
        logic        rec, play, stop;
        logic [1:0]  sl;
        logic        rfin, pfin;
        logic [19:0] addr;
        logic [2:0]  st;
        logic [8:0]  ctl;
        logic [3:0]  vld;
        logic [19:0] sa;
        logic [19:0] ba;
    } vec_t;

    vec_t vecs[$];

    // Behavioural model: spec rules over slots, lengths and a mode number.
    int          m_st;
    int          m_cnt;
    logic [1:0]  m_slot;
    logic [19:0] m_len [4];
    logic [3:0]  m_vld;

    function automatic vec_t mk(input logic rec, play, stop, input logic [1:0] sl,
                                input logic rfin, pfin, input logic [19:0] addr,
                                input logic [2:0] st, input logic [8:0] c,
                                input logic [3:0] vld, input logic [19:0] sa, ba);
        vec_t v;
        v.rec = rec; v.play = play; v.stop = stop; v.sl = sl;
        v.rfin = rfin; v.pfin = pfin; v.addr = addr;
        v.st = st; v.ctl = c; v.vld = vld; v.sa = sa; v.ba = ba;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [2:0] st, input logic [8:0] c,
                           input logic [3:0] vld, input logic [19:0] sa, ba);
        chk({tag, ".state"}, 32'(state), 32'(st));
        chk({tag, ".ctl"},   32'(ctl),   32'(c));
        chk({tag, ".valid"}, 32'(slot_valid), 32'(vld));
        chk({tag, ".stop"},  32'(stop_addr),  32'(sa));
        chk({tag, ".base"},  32'(base_addr),  32'(ba));
    endtask

    task automatic drive(input logic rec, play, stop, input logic [1:0] sl,
                         input logic rfin, pfin, input logic [19:0] addr);
        key_rec = rec; key_play = play; key_stop = stop; slot = sl;
        rec_fin = rfin; play_fin = pfin; rec_addr = addr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [8:0] exp_ctl(input int st, input logic i2c, rs, ds, lf);
        logic [8:0] c;
        c = 9'b000000001;
        case (st)
            2: begin c[7] = 1'b1; c[0] = 1'b0; end
            3: c[6] = 1'b1;
            4: begin c[4] = !lf; c[1] = 1'b1; end
            5: c[3] = 1'b1;
            default: ;
        endcase
        c[8] = i2c;
        c[5] = rs;
        c[2] = ds;
        return c;
    endfunction

    task automatic model_reset();
        m_st = 1; m_cnt = 0; m_slot = '0; m_vld = '0;
        for (int i = 0; i < 4; i++) m_len[i] = '0;
    endtask

    task automatic model_step(input logic rec, play, stop, fin_i2c, rfin, pfin,
                              input logic [1:0] sl, input logic [19:0] addr);
        logic rs, ds, lf, i2c;
        int   nxt;
        rs = 1'b0; ds = 1'b0; lf = 1'b0;
        nxt = m_st;
        if (m_st == 1) begin
            if (fin_i2c) nxt = 0;
        end else if (m_st == 0) begin
            if (rec) begin m_slot = sl; nxt = 2; end
            else if (play && m_vld[sl]) begin m_slot = sl; nxt = 4; end
        end else if (m_st == 2 || m_st == 3) begin
            if (stop || (rfin && m_st == 2)) begin
                m_len[m_slot] = addr; m_vld[m_slot] = 1'b1; nxt = 0; rs = 1'b1;
            end else if (rec) begin
                nxt = (m_st == 2) ? 3 : 2;
            end
        end else if (m_st == 4) begin
            if (stop) begin nxt = 0; ds = 1'b1; end
            else if (pfin) begin
                ds = 1'b1;
`ifdef REC_PLAY_LOOP_EN
                lf = 1'b1;
`else
                nxt = 0;
`endif
            end else if (play) nxt = 5;
        end else if (m_st == 5) begin
            if (stop) begin nxt = 0; ds = 1'b1; end
            else if (play) nxt = 4;
        end
        i2c = (nxt == 1) && (m_cnt < INIT_CYC);
        if (m_st == 1 && m_cnt < INIT_CYC) m_cnt++;
        m_st = nxt;
        exp_q.push_back({3'(m_st), exp_ctl(m_st, i2c, rs, ds, lf), m_vld,
                         m_len[m_slot], {m_slot, 18'b0}});
    endtask

    initial begin
        logic [55:0] e;
        logic        r, p, s, f2, rf, pf;
        logic [1:0]  sl;
        logic [19:0] ad;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 3'd1, C_IDLE, 4'b0, 20'h0, 20'h0);

        // Init sequence: i2c_start high cycles 1..4, exit at cycle 10, keys ignored
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            i2c_fin = (k >= 10);
            key_rec = (k == 6);
            tick();
            chk("init.i2c", 32'(i2c_start), 32'(k <= 4));
            chk("init.state", 32'(state), (k >= 10) ? 32'd0 : 32'd1);
        end
        key_rec = 1'b0;

        // Directed vectors
        vecs.push_back(mk(1,0,0,2'd2,0,0,20'h00000, 3'd2, C_RECD, 4'b0000, 20'h00000, 20'h80000));
        vecs.push_back(mk(0,0,0,2'd0,0,0,20'h80100, 3'd2, C_RECD, 4'b0000, 20'h00000, 20'h80000));
        vecs.push_back(mk(0,0,1,2'd0,0,0,20'h80123, 3'd0, C_RSTP, 4'b0100, 20'h80123, 20'h80000));
        vecs.push_back(mk(0,0,0,2'd0,0,0,20'h00000, 3'd0, C_IDLE, 4'b0100, 20'h80123, 20'h80000));
        vecs.push_back(mk(0,1,0,2'd1,0,0,20'h00000, 3'd0, C_IDLE, 4'b0100, 20'h80123, 20'h80000));
        vecs.push_back(mk(0,1,0,2'd2,0,0,20'h00000, 3'd4, C_PLAY, 4'b0100, 20'h80123, 20'h80000));
        vecs.push_back(mk(0,1,0,2'd0,0,0,20'h00000, 3'd5, C_PPAU, 4'b0100, 20'h80123, 20'h80000));
        vecs.push_back(mk(0,1,0,2'd0,0,0,20'h00000, 3'd4, C_PLAY, 4'b0100, 20'h80123, 20'h80000));
        vecs.push_back(mk(0,1,1,2'd0,0,0,20'h00000, 3'd0, C_DSTP, 4'b0100, 20'h80123, 20'h80000));
        vecs.push_back(mk(0,0,0,2'd0,0,0,20'h00000, 3'd0, C_IDLE, 4'b0100, 20'h80123, 20'h80000));
        vecs.push_back(mk(1,1,0,2'd1,0,0,20'h00000, 3'd2, C_RECD, 4'b0100, 20'h00000, 20'h40000));
        vecs.push_back(mk(1,0,0,2'd1,0,0,20'h00000, 3'd3, C_RPAU, 4'b0100, 20'h00000, 20'h40000));
        vecs.push_back(mk(0,0,0,2'd1,1,0,20'h40055, 3'd3, C_RPAU, 4'b0100, 20'h00000, 20'h40000));
        vecs.push_back(mk(1,0,0,2'd1,0,0,20'h00000, 3'd2, C_RECD, 4'b0100, 20'h00000, 20'h40000));
        vecs.push_back(mk(0,0,0,2'd1,1,0,20'h40077, 3'd0, C_RSTP, 4'b0110, 20'h40077, 20'h40000));
        vecs.push_back(mk(0,1,0,2'd2,0,0,20'h00000, 3'd4, C_PLAY, 4'b0110, 20'h80123, 20'h80000));
`ifdef REC_PLAY_LOOP_EN
        vecs.push_back(mk(0,0,0,2'd0,0,1,20'h00000, 3'd4, C_LOOP, 4'b0110, 20'h80123, 20'h80000));
        vecs.push_back(mk(0,0,0,2'd0,0,0,20'h00000, 3'd4, C_PLAY, 4'b0110, 20'h80123, 20'h80000));
        vecs.push_back(mk(0,0,1,2'd0,0,0,20'h00000, 3'd0, C_DSTP, 4'b0110, 20'h80123, 20'h80000));
`else
        vecs.push_back(mk(0,0,0,2'd0,0,1,20'h00000, 3'd0, C_DSTP, 4'b0110, 20'h80123, 20'h80000));
        vecs.push_back(mk(0,0,0,2'd0,0,0,20'h00000, 3'd0, C_IDLE, 4'b0110, 20'h80123, 20'h80000));
        vecs.push_back(mk(0,0,1,2'd0,0,0,20'h00000, 3'd0, C_IDLE, 4'b0110, 20'h80123, 20'h80000));
`endif
        vecs.push_back(mk(1,0,0,2'd2,0,0,20'h00000, 3'd2, C_RECD, 4'b0110, 20'h80123, 20'h80000));
        vecs.push_back(mk(0,0,1,2'd0,0,0,20'h80200, 3'd0, C_RSTP, 4'b0110, 20'h80200, 20'h80000));
        vecs.push_back(mk(1,0,0,2'd3,0,0,20'h00000, 3'd2, C_RECD, 4'b0110, 20'h00000, 20'hC0000));
        vecs.push_back(mk(1,0,0,2'd0,0,0,20'h00000, 3'd3, C_RPAU, 4'b0110, 20'h00000, 20'hC0000));
        vecs.push_back(mk(0,0,1,2'd0,0,0,20'hC0010, 3'd0, C_RSTP, 4'b1110, 20'hC0010, 20'hC0000));
        vecs.push_back(mk(0,1,0,2'd0,0,0,20'h00000, 3'd0, C_IDLE, 4'b1110, 20'hC0010, 20'hC0000));

        foreach (vecs[i]) begin
            drive(vecs[i].rec, vecs[i].play, vecs[i].stop, vecs[i].sl,
                  vecs[i].rfin, vecs[i].pfin, vecs[i].addr);
            tick();
            chk_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].ctl,
                    vecs[i].vld, vecs[i].sa, vecs[i].ba);
        end

        // Reset asserted mid-record: no store, no stop pulse
        drive(1, 0, 0, 2'd1, 0, 0, 20'h4_1234);
        tick();
        chk("midrec.enter", 32'(state), 32'd2);
        drive(0, 0, 0, 2'd1, 0, 0, 20'h4_1234);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("midrec.reset", 3'd1, C_IDLE, 4'b0, 20'h0, 20'h0);
        tick();
        chk("midrec.hold", 32'(ctl), 32'(C_IDLE));

        // Randomized run from a fresh reset against the model
        i2c_fin = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 400; j++) begin
            r  = ($urandom_range(0, 3) == 0);
            p  = ($urandom_range(0, 3) == 0);
            s  = ($urandom_range(0, 5) == 0);
            rf = ($urandom_range(0, 9) == 0);
            pf = ($urandom_range(0, 9) == 0);
            f2 = (j >= 6);
            sl = 2'($urandom_range(0, 3));
            ad = 20'($urandom);
            i2c_fin = f2;
            drive(r, p, s, sl, rf, pf, ad);
            model_step(r, p, s, f2, rf, pf, sl, ad);
            tick();
            e = exp_q.pop_front();
            chk("rnd.state", 32'(state),      32'(e[55:53]));
            chk("rnd.ctl",   32'(ctl),        32'(e[52:44]));
            chk("rnd.valid", 32'(slot_valid), 32'(e[43:40]));
            chk("rnd.stop",  32'(stop_addr),  32'(e[39:20]));
            chk("rnd.base",  32'(base_addr),  32'(e[19:0]));
        end
        drive(0, 0, 0, 2'd0, 0, 0, 20'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
